// File: rtl/memory_pkg.sv
// memory_pkg: shared widths, beat record and FSM state type for memory_reader.
// The module parameters W/D of memory_reader are expected to match MEM_W/MEM_D here.
package memory_pkg;

   localparam int unsigned MEM_W = 16;
   localparam int unsigned MEM_D = 256;
   localparam int unsigned MEM_A = $clog2(MEM_D);

   typedef logic [MEM_A-1:0] addr_t;
   typedef logic [MEM_W-1:0] data_t;
   typedef logic [MEM_A:0]   count_t;

   typedef struct packed {
      logic  last;
      data_t data;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/memory_reader_fifo.sv
// memory_reader_fifo: synchronous in-order FIFO with valid/ready on both sides and an occupancy count.
module memory_reader_fifo
   import memory_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = beat_t
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  T                         in_data_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output T                         out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   occ_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0] wr_q, wr_d;
   logic [PW:0] rd_q, rd_d;
   T            mem_q [DEPTH];
   logic        push, pop;

   always_comb begin
      occ_o       = wr_q - rd_q;
      in_ready_o  = (occ_o != (PW+1)'(DEPTH));
      out_valid_o = (occ_o != '0);
      out_data_o  = mem_q[rd_q[PW-1:0]];
      push        = in_valid_i && in_ready_o;
      pop         = out_valid_o && out_ready_i;
      wr_d        = push ? wr_q + (PW+1)'(1) : wr_q;
      rd_d        = pop  ? rd_q + (PW+1)'(1) : rd_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted by the pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_q[PW-1:0]] <= in_data_i;
      end
   end

endmodule

// File: rtl/memory_reader.sv
// memory_reader: turns {count, addr} commands into sequential ar reads and an ordered {last, data} stream.
// Define MEMORY_READER_STRIDE_EN to add a per-command stride field: cmd_data = {stride, count, addr}.
module memory_reader
   import memory_pkg::*;
#(
   parameter int unsigned W     = MEM_W,
   parameter int unsigned D     = MEM_D,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef MEMORY_READER_STRIDE_EN
   input  logic [3*$clog2(D):0]      cmd_data,
`else
   input  logic [2*$clog2(D):0]      cmd_data,
`endif
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   output logic [$clog2(D)-1:0]      ar_data,
   output logic                      ar_valid,
   input  logic                      ar_ready,
   input  logic [W-1:0]              r_data,
   input  logic                      r_valid,
   output logic                      r_ready,
   output logic [W:0]                out_data,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int unsigned A  = $clog2(D);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t        state_q, state_d;
   logic          live_q;
   addr_t         addr_q, addr_d;
   addr_t         stride_q, stride_d;
   count_t        count_q, count_d;
   count_t        remain_q, remain_d;
   count_t        rcvd_q, rcvd_d;
   logic [CW-1:0] outst_q, outst_d;

   addr_t         cmd_addr, cmd_stride;
   count_t        cmd_count;
   logic          cmd_fire, ar_fire, r_fire;
   logic [CW:0]   credits;

   beat_t         fifo_in, fifo_out;
   logic          fifo_in_valid, fifo_in_ready, fifo_out_valid;
   logic [CW-1:0] occ;

   assign cmd_addr  = cmd_data[A-1:0];
   assign cmd_count = cmd_data[2*A:A];
`ifdef MEMORY_READER_STRIDE_EN
   assign cmd_stride = cmd_data[3*A:2*A+1];
`else
   assign cmd_stride = addr_t'(1);
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      count_d  = count_q;
      remain_d = remain_q;
      rcvd_d   = rcvd_q;
      outst_d  = outst_q;

      // Credits count both reads in flight and buffered beats, so an accepted r beat always fits.
      credits       = {1'b0, outst_q} + {1'b0, occ};
      cmd_ready     = live_q && (state_q == IDLE);
      ar_valid      = (state_q == RUN) && (credits < (CW+1)'(DEPTH));
      ar_data       = addr_q;
      r_ready       = (outst_q != '0);
      cmd_fire      = cmd_valid && cmd_ready;
      ar_fire       = ar_valid && ar_ready;
      r_fire        = r_valid && r_ready && fifo_in_ready;
      fifo_in_valid = r_fire;
      fifo_in.last  = ((rcvd_q + count_t'(1)) == count_q);
      fifo_in.data  = r_data;
      out_valid     = fifo_out_valid;
      out_data      = fifo_out_valid ? {fifo_out.last, fifo_out.data} : '0;

      case ({ar_fire, r_fire})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase

      if (r_fire) begin
         rcvd_d = rcvd_q + count_t'(1);
      end

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               addr_d   = cmd_addr;
               stride_d = cmd_stride;
               count_d  = cmd_count;
               remain_d = cmd_count;
               rcvd_d   = '0;
               if (cmd_count != '0) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (ar_fire) begin
               addr_d   = addr_q + stride_q;
               remain_d = remain_q - count_t'(1);
               if (remain_q == count_t'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((outst_q == '0) && !fifo_out_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         live_q   <= 1'b0;
         addr_q   <= '0;
         stride_q <= '0;
         count_q  <= '0;
         remain_q <= '0;
         rcvd_q   <= '0;
         outst_q  <= '0;
      end else begin
         state_q  <= state_d;
         live_q   <= 1'b1;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         count_q  <= count_d;
         remain_q <= remain_d;
         rcvd_q   <= rcvd_d;
         outst_q  <= outst_d;
      end
   end

   memory_reader_fifo #(
      .DEPTH (DEPTH),
      .T     (beat_t)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .in_data_i   (fifo_in),
      .in_valid_i  (fifo_in_valid),
      .in_ready_o  (fifo_in_ready),
      .out_data_o  (fifo_out),
      .out_valid_o (fifo_out_valid),
      .out_ready_i (out_ready),
      .occ_o       (occ)
   );

endmodule

// File: tb/tb_memory_reader.sv
// tb_memory_reader: table-driven directed cases plus random commands against a queue-based memory/stream model.
`timescale 1ns/1ps
module tb_memory_reader;

   localparam int W     = 16;
   localparam int D     = 256;
   localparam int A     = 8;
   localparam int DEPTH = 4;
`ifdef MEMORY_READER_STRIDE_EN
   localparam int CMDW  = 3*A+1;
`else
   localparam int CMDW  = 2*A+1;
`endif
   localparam int IDLE_BUDGET = 3000;

   logic            clk = 1'b0;
   logic            rst;
   logic [CMDW-1:0] cmd_data;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [A-1:0]    ar_data;
   logic            ar_valid;
   logic            ar_ready;
   logic [W-1:0]    r_data;
   logic            r_valid;
   logic            r_ready;
   logic [W:0]      out_data;
   logic            out_valid;
   logic            out_ready;

   memory_reader #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .ar_data   (ar_data),
      .ar_valid  (ar_valid),
      .ar_ready  (ar_ready),
      .r_data    (r_data),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural memory contents and expectations derived from each accepted command
   logic [W-1:0] mem [D];
   typedef struct {int addr; int due;} req_t;
   req_t         pend[$];
   int           exp_ar[$];
   logic [W:0]   exp_out[$];

   int  cyc = 0;
   int  out_prob = 100, ar_prob = 100, lat_max = 1;
   bit  bogus_en = 1'b0;
   int  ar_total = 0, out_total = 0, cmd_beats = 0, last_seen = 0;
   logic [W-1:0] first_data, last_data;

   // Memory responder and output monitor; all decisions are made at the falling edge for the next rising edge
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         pend.delete();
         ar_ready  = 1'b0;
         r_valid   = 1'b0;
         r_data    = '0;
         out_ready = 1'b0;
      end else begin
         ar_ready = ($urandom_range(99) < ar_prob);
         if (ar_valid && ar_ready) begin
            ar_total++;
            if (exp_ar.size() == 0) check("ar_unexpected", ar_valid, 0);
            else check("ar_addr", ar_data, exp_ar.pop_front());
            pend.push_back('{int'(ar_data), cyc + int'($urandom_range(lat_max, 1))});
         end
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            r_valid = 1'b1;
            r_data  = mem[pend[0].addr];
            check("r_ready_busy", r_ready, 1);
            if (r_ready) void'(pend.pop_front());
         end else if (bogus_en && pend.size() == 0 && $urandom_range(9) == 0) begin
            r_valid = 1'b1;
            r_data  = W'($urandom);
            check("r_ready_idle", r_ready, 0);
         end else begin
            r_valid = 1'b0;
            r_data  = '0;
         end

         out_ready = ($urandom_range(99) < out_prob);
         if (out_valid) begin
            if (exp_out.size() == 0) check("out_unexpected", out_valid, 0);
            else if (out_ready) begin
               check("out_beat", out_data, exp_out.pop_front());
               out_total++;
               cmd_beats++;
               if (cmd_beats == 1) first_data = out_data[W-1:0];
               if (out_data[W]) begin
                  last_seen++;
                  last_data = out_data[W-1:0];
               end
            end
         end
      end
   end

   task automatic send_cmd(input int cnt, input int addr, input int stride);
      int n = 0;
`ifdef MEMORY_READER_STRIDE_EN
      cmd_data = {A'(stride), (A+1)'(cnt), A'(addr)};
`else
      cmd_data = {(A+1)'(cnt), A'(addr)};
`endif
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         errors++;
         checks++;
         $display("FAIL cmd_accept_timeout: cmd_ready got 0 expected 1");
         cmd_valid = 1'b0;
         return;
      end
      for (int i = 0; i < cnt; i++) begin
         int a;
         a = (addr + i * stride) % D;
         exp_ar.push_back(a);
         exp_out.push_back({i == cnt - 1, mem[a]});
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int ncyc);
      ncyc = 0;
      do begin
         @(negedge clk);
         ncyc++;
      end while (!(exp_out.size() == 0 && exp_ar.size() == 0 && cmd_ready) && ncyc < IDLE_BUDGET);
      if (ncyc >= IDLE_BUDGET) begin
         errors++;
         checks++;
         $display("FAIL idle_timeout: beats left %0d, addrs left %0d, cmd_ready %0d", exp_out.size(), exp_ar.size(), cmd_ready);
      end
   endtask

   typedef struct {
      int cnt, addr, stall, out_prob, ar_prob, lat, max_cyc;
      int exp_beats, exp_first, exp_last;
   } vec_t;
   vec_t vt[5];

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ncyc, n;
      vt[0] = '{256,   0,  0, 100, 100, 1, 266, 256,   0, 765};
      vt[1] = '{  4, 254,  0, 100, 100, 2,   0,   4, 762,   3};
      vt[2] = '{ 16,   8, 20, 100, 100, 1,   0,  16,  24,  69};
      vt[3] = '{  7, 100,  0,  50,  50, 3,   0,   7, 300, 318};
      vt[4] = '{  1, 255,  0, 100, 100, 1,   0,   1, 765, 765};
      for (int i = 0; i < D; i++) mem[i] = W'(i * 3);

      rst = 1'b0;
      cmd_valid = 1'b0;
      cmd_data = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_ar_valid",  ar_valid,  0);
      check("rst_ar_data",   ar_data,   0);
      check("rst_r_ready",   r_ready,   0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1);

      for (int t = 0; t < 5; t++) begin
         ar_prob   = vt[t].ar_prob;
         lat_max   = vt[t].lat;
         out_prob  = (vt[t].stall > 0) ? 0 : vt[t].out_prob;
         cmd_beats = 0;
         last_seen = 0;
         ar_total  = 0;
         out_total = 0;
         send_cmd(vt[t].cnt, vt[t].addr, 1);
         if (vt[t].stall > 0) begin
            repeat (vt[t].stall) @(negedge clk);
            check("bp_ar_count", ar_total, DEPTH);
            check("bp_no_beats", out_total, 0);
            out_prob = vt[t].out_prob;
         end
         wait_idle(ncyc);
         check("vec_beats", cmd_beats, vt[t].exp_beats);
         check("vec_first", first_data, vt[t].exp_first);
         check("vec_last_data", last_data, vt[t].exp_last);
         check("vec_last_once", last_seen, 1);
         if (vt[t].max_cyc > 0) check("vec_throughput", ncyc <= vt[t].max_cyc, 1);
      end

      // Zero count: accepted, nothing issued, ready again immediately
      ar_total = 0;
      out_total = 0;
      send_cmd(0, 5, 1);
      check("zero_cmd_ready", cmd_ready, 1);
      repeat (5) begin
         @(negedge clk);
         check("zero_ar_valid", ar_valid, 0);
         check("zero_out_valid", out_valid, 0);
      end
      check("zero_ar_total", ar_total, 0);

      // Reset in the middle of a 10-beat command
      out_prob = 100;
      ar_prob = 100;
      lat_max = 1;
      cmd_beats = 0;
      send_cmd(10, 0, 1);
      n = 0;
      while (cmd_beats < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_beats_before_rst", cmd_beats >= 3, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_cmd_ready", cmd_ready, 0);
      check("mid_rst_ar_valid",  ar_valid,  0);
      check("mid_rst_ar_data",   ar_data,   0);
      check("mid_rst_r_ready",   r_ready,   0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data",  out_data,  0);
      exp_out.delete();
      exp_ar.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cmd_beats = 0;
      last_seen = 0;
      send_cmd(2, 0, 1);
      wait_idle(ncyc);
      check("post_rst_beats", cmd_beats, 2);
      check("post_rst_first", first_data, 0);
      check("post_rst_last",  last_data, 3);
      check("post_rst_last_once", last_seen, 1);

      // Random commands with random stalls, latencies and stray r_valid pulses
      bogus_en = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         int cnt, addr, stride;
         cnt = ($urandom_range(99) < 3) ? int'($urandom_range(D, 17)) : int'($urandom_range(16, 0));
         addr = int'($urandom_range(D - 1, 0));
`ifdef MEMORY_READER_STRIDE_EN
         stride = int'($urandom_range(D - 1, 0));
`else
         stride = 1;
`endif
         case ($urandom_range(2, 0))
            0:       out_prob = 25;
            1:       out_prob = 60;
            default: out_prob = 100;
         endcase
         ar_prob = ($urandom_range(1, 0) == 0) ? 50 : 100;
         lat_max = int'($urandom_range(3, 1));
         cmd_beats = 0;
         last_seen = 0;
         send_cmd(cnt, addr, stride);
         wait_idle(ncyc);
         check("rnd_beats", cmd_beats, cnt);
         check("rnd_last_once", last_seen, (cnt > 0) ? 1 : 0);
      end
      bogus_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
